immediate_gen: RTL and testbench

IMMEDIATE_GEN -- requirements
Module: immediate_gen

---
 rtl/immediate_gen_pkg.sv | 29 ++
 rtl/immediate_gen_imm_decode.sv | 57 +++++
 rtl/immediate_gen.sv | 70 +++++++
 tb/tb_immediate_gen.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/immediate_gen_pkg.sv
// Shared RV32I opcode constants and the immediate format code.
package immediate_gen_pkg;

    localparam int unsigned OPCODE_W = 7;
    localparam int unsigned XLEN     = 32;
    localparam int unsigned FMT_W    = 3;

    localparam logic [OPCODE_W-1:0] I_LOAD_OPCODE  = 7'b0000011;
    localparam logic [OPCODE_W-1:0] I_ARITH_OPCODE = 7'b0010011;
    localparam logic [OPCODE_W-1:0] JALR_OPCODE    = 7'b1100111;
    localparam logic [OPCODE_W-1:0] S_TYPE_OPCODE  = 7'b0100011;
    localparam logic [OPCODE_W-1:0] B_TYPE_OPCODE  = 7'b1100011;
    localparam logic [OPCODE_W-1:0] LUI_OPCODE     = 7'b0110111;
    localparam logic [OPCODE_W-1:0] AUIPC_OPCODE   = 7'b0010111;
    localparam logic [OPCODE_W-1:0] JAL_OPCODE     = 7'b1101111;
    localparam logic [OPCODE_W-1:0] R_TYPE_OPCODE  = 7'b0110011;
    localparam logic [OPCODE_W-1:0] SYSTEM_OPCODE  = 7'b1110011;
    localparam logic [OPCODE_W-1:0] FENCE_OPCODE   = 7'b0001111;

    typedef enum logic [FMT_W-1:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5
    } imm_fmt_e;

endpackage

// File: rtl/immediate_gen_imm_decode.sv
// Opcode to immediate-format decoder with illegal-opcode flag.
module imm_decode
    import immediate_gen_pkg::*;
(
    input  logic [6:0] i_opcode,
    output logic [2:0] o_fmt,
    output logic       o_illegal
);

    imm_fmt_e fmt;
    logic     illegal;

    // Map each recognised opcode to its format; anything else is illegal.
    always_comb begin
        fmt     = FMT_NONE;
        illegal = 1'b1;
        case (i_opcode)
            I_LOAD_OPCODE,
            I_ARITH_OPCODE,
            JALR_OPCODE,
            SYSTEM_OPCODE,
            FENCE_OPCODE: begin
                fmt     = FMT_I;
                illegal = 1'b0;
            end
            S_TYPE_OPCODE: begin
                fmt     = FMT_S;
                illegal = 1'b0;
            end
            B_TYPE_OPCODE: begin
                fmt     = FMT_B;
                illegal = 1'b0;
            end
            LUI_OPCODE,
            AUIPC_OPCODE: begin
                fmt     = FMT_U;
                illegal = 1'b0;
            end
            JAL_OPCODE: begin
                fmt     = FMT_J;
                illegal = 1'b0;
            end
            R_TYPE_OPCODE: begin
                fmt     = FMT_NONE;
                illegal = 1'b0;
            end
            default: begin
                fmt     = FMT_NONE;
                illegal = 1'b1;
            end
        endcase
    end

    assign o_fmt     = fmt;
    assign o_illegal = illegal;

endmodule

// File: rtl/immediate_gen.sv
// RV32I immediate generator: combinational immediate plus a one-cycle registered copy.
module immediate_gen
    import immediate_gen_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [6:0]  i_opcode,
    input  logic [31:0] i_instr,
    output logic [31:0] o_ext_imm,
    output logic [2:0]  o_imm_fmt,
    output logic        o_illegal,
    output logic [31:0] o_ext_imm_r,
    output logic [2:0]  o_imm_fmt_r
);

    logic [FMT_W-1:0] imm_fmt;
    logic [XLEN-1:0]  ext_imm;
    logic [XLEN-1:0]  ext_imm_d;
    logic [XLEN-1:0]  ext_imm_q;
    logic [FMT_W-1:0] imm_fmt_d;
    logic [FMT_W-1:0] imm_fmt_q;

    // The format comes from i_opcode alone; the instruction's own opcode field is ignored.
    logic unused_instr_opcode;
    assign unused_instr_opcode = ^i_instr[6:0];

    imm_decode u_imm_decode (
        .i_opcode  (i_opcode),
        .o_fmt     (imm_fmt),
        .o_illegal (o_illegal)
    );

    // Assemble the immediate for the decoded format; bit 31 is the sign for all extended formats.
    always_comb begin
        ext_imm = '0;
        case (imm_fmt)
            FMT_I: ext_imm = {{20{i_instr[31]}}, i_instr[31:20]};
            FMT_S: ext_imm = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
            FMT_B: ext_imm = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                              i_instr[30:25], i_instr[11:8], 1'b0};
            FMT_U: ext_imm = {i_instr[31:12], 12'b0};
            FMT_J: ext_imm = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12],
                              i_instr[20], i_instr[30:21], 1'b0};
            default: ext_imm = '0;
        endcase
    end

    // Next register values are simply the current combinational results.
    always_comb begin
        ext_imm_d = ext_imm;
        imm_fmt_d = imm_fmt;
    end

    // Output register, loaded every edge and cleared asynchronously by reset.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ext_imm_q <= '0;
            imm_fmt_q <= FMT_NONE;
        end else begin
            ext_imm_q <= ext_imm_d;
            imm_fmt_q <= imm_fmt_d;
        end
    end

    assign o_ext_imm   = ext_imm;
    assign o_imm_fmt   = imm_fmt;
    assign o_ext_imm_r = ext_imm_q;
    assign o_imm_fmt_r = imm_fmt_q;

endmodule

// File: tb/tb_immediate_gen.sv
// Directed bench for immediate_gen with hand-computed expected values.
module tb_immediate_gen;
    import immediate_gen_pkg::*;

    logic        i_clk;
    logic        i_rst;
    logic [6:0]  i_opcode;
    logic [31:0] i_instr;
    logic [31:0] o_ext_imm;
    logic [2:0]  o_imm_fmt;
    logic        o_illegal;
    logic [31:0] o_ext_imm_r;
    logic [2:0]  o_imm_fmt_r;

    int checks = 0;
    int errors = 0;

    immediate_gen dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_opcode    (i_opcode),
        .i_instr     (i_instr),
        .o_ext_imm   (o_ext_imm),
        .o_imm_fmt   (o_imm_fmt),
        .o_illegal   (o_illegal),
        .o_ext_imm_r (o_ext_imm_r),
        .o_imm_fmt_r (o_imm_fmt_r)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [6:0] op, input logic [31:0] instr);
        @(negedge i_clk);
        i_opcode = op;
        i_instr  = instr;
        #1;
    endtask

    task automatic comb(input string tag, input logic [31:0] imm, input logic [2:0] fmt,
                        input logic ill);
        chk({tag, "_imm"}, o_ext_imm, imm);
        chk({tag, "_fmt"}, 32'(o_imm_fmt), 32'(fmt));
        chk({tag, "_ill"}, 32'(o_illegal), 32'(ill));
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        i_rst    = 1'b1;
        i_opcode = I_LOAD_OPCODE;
        i_instr  = 32'h0030_8103;
        #2;
        chk("rst_imm_r", o_ext_imm_r, 32'h0);
        chk("rst_fmt_r", 32'(o_imm_fmt_r), 32'(FMT_NONE));
        comb("rst_comb_lw", 32'd3, FMT_I, 1'b0);

        @(posedge i_clk); #1;
        chk("rst_held_imm_r", o_ext_imm_r, 32'h0);

        @(negedge i_clk);
        i_rst = 1'b0;
        @(posedge i_clk); #1;
        chk("post_rst_imm_r", o_ext_imm_r, 32'd3);
        chk("post_rst_fmt_r", 32'(o_imm_fmt_r), 32'(FMT_I));

        drive(I_ARITH_OPCODE, 32'hFFF0_8113);
        comb("addi_m1", 32'hFFFF_FFFF, FMT_I, 1'b0);
        chk("latency_old_imm_r", o_ext_imm_r, 32'd3);
        @(posedge i_clk); #1;
        chk("addi_imm_r", o_ext_imm_r, 32'hFFFF_FFFF);

        drive(S_TYPE_OPCODE, 32'h0021_2223);
        comb("sw", 32'd4, FMT_S, 1'b0);
        @(posedge i_clk); #1;
        chk("sw_fmt_r", 32'(o_imm_fmt_r), 32'(FMT_S));

        drive(B_TYPE_OPCODE, 32'h0020_8463);
        comb("beq8", 32'd8, FMT_B, 1'b0);
        drive(B_TYPE_OPCODE, 32'hFE00_0FE3);
        comb("beq_m2", 32'hFFFF_FFFE, FMT_B, 1'b0);

        drive(LUI_OPCODE, 32'h0000_10B7);
        comb("lui", 32'd4096, FMT_U, 1'b0);
        drive(AUIPC_OPCODE, 32'h0000_10B7);
        comb("auipc", 32'd4096, FMT_U, 1'b0);
        drive(LUI_OPCODE, 32'hFFFF_F037);
        comb("lui_top", 32'hFFFF_F000, FMT_U, 1'b0);

        drive(JAL_OPCODE, 32'h2000_006F);
        comb("jal512", 32'd512, FMT_J, 1'b0);
        drive(JAL_OPCODE, 32'h8000_006F);
        comb("jal_neg", 32'hFFF0_0000, FMT_J, 1'b0);
        @(posedge i_clk); #1;
        chk("jal_imm_r", o_ext_imm_r, 32'hFFF0_0000);
        chk("jal_fmt_r", 32'(o_imm_fmt_r), 32'(FMT_J));

        drive(JALR_OPCODE, 32'h8000_0067);
        comb("jalr_neg", 32'hFFFF_F800, FMT_I, 1'b0);
        drive(SYSTEM_OPCODE, 32'h8000_0073);
        comb("system", 32'hFFFF_F800, FMT_I, 1'b0);
        drive(FENCE_OPCODE, 32'h0FF0_000F);
        comb("fence", 32'h0000_00FF, FMT_I, 1'b0);

        drive(7'b1111111, 32'hFFFF_FFFF);
        comb("illegal_7f", 32'h0, FMT_NONE, 1'b1);
        drive(R_TYPE_OPCODE, 32'hFFFF_FFFF);
        comb("rtype", 32'h0, FMT_NONE, 1'b0);
        drive(7'b0000000, 32'h8000_0000);
        comb("illegal_00", 32'h0, FMT_NONE, 1'b1);

        drive(JAL_OPCODE, 32'h8000_006F);
        @(posedge i_clk); #1;
        chk("pre_rst_imm_r", o_ext_imm_r, 32'hFFF0_0000);
        @(negedge i_clk); #1;
        i_rst = 1'b1;
        #1;
        chk("mid_rst_imm_r", o_ext_imm_r, 32'h0);
        chk("mid_rst_fmt_r", 32'(o_imm_fmt_r), 32'(FMT_NONE));
        chk("mid_rst_comb", o_ext_imm, 32'hFFF0_0000);
        i_opcode = I_ARITH_OPCODE;
        i_instr  = 32'hFFF0_8113;
        #1;
        i_rst = 1'b0;
        #1;
        chk("rel_no_edge_imm_r", o_ext_imm_r, 32'h0);
        @(posedge i_clk); #1;
        chk("rel_addi_imm_r", o_ext_imm_r, 32'hFFFF_FFFF);
        chk("rel_addi_fmt_r", 32'(o_imm_fmt_r), 32'(FMT_I));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
